// File: rtl/data_path_wide.sv
// data_path_wide: multi-cycle datapath with register file, ALU, PC/IR, flags and a
// single-outstanding data-memory interface. Externally sequenced through load enables
// and mux selects.
//
// Instruction memory is a ROM whose contents come from IMEM_INIT. Word i occupies
// bits [i*IW +: IW]. It is never reset.
//
// Ports:
//   clk, reset (async, active-low)
//   ir_write, pc_write, reg_write, alu_write, flag_write : register load enables
//   mem_start, mem_we                                    : data-memory transaction request
//   alu_sel1, alu_sel2, result_sel, alu_op               : datapath steering
//   opcode, zero, carry, mem_busy                        : status to the controller
//   dmem_req, dmem_we, dmem_addr, dmem_wdata,
//   dmem_rdata, dmem_ack                                 : data-memory bus
//
// Optional feature: define DATA_PATH_WIDE_CARRY_EN to build the carry flag.
// Without it, carry is tied to 0.

package data_path_wide_pkg;
    typedef enum logic [2:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluPassA, AluPassB, AluShl
    } alu_operation_t;
    typedef logic [3:0] opcode_t;
endpackage

module data_path_wide
    import data_path_wide_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REG_COUNT  = 4,
    parameter int unsigned IMEM_DEPTH = 16,
    parameter logic [IMEM_DEPTH*(4+2*$clog2(REG_COUNT))-1:0] IMEM_INIT = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ir_write,
    input  logic                  pc_write,
    input  logic                  reg_write,
    input  logic                  alu_write,
    input  logic                  flag_write,
    input  logic                  mem_start,
    input  logic                  mem_we,
    input  logic [1:0]            alu_sel1,
    input  logic [1:0]            alu_sel2,
    input  logic [1:0]            result_sel,
    input  alu_operation_t        alu_op,
    output opcode_t               opcode,
    output logic                  zero,
    output logic                  carry,
    output logic                  mem_busy,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack
);
    localparam int unsigned RA_W = $clog2(REG_COUNT);
    localparam int unsigned IW   = 4 + 2 * RA_W;

    typedef enum logic {StIdle, StReq} mem_state_e;

    logic [DATA_WIDTH-1:0] r_pc, r_alu_out, r_mdr;
    logic [IW-1:0]         r_ir;
    logic                  r_zero;
    logic [DATA_WIDTH-1:0] r_rf [REG_COUNT];
    mem_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_dmem_addr, r_dmem_wdata;
    logic                  r_dmem_we;

    logic [RA_W-1:0]       w_rd, w_rs;
    logic [DATA_WIDTH-1:0] w_rd_data, w_rs_data, w_imm_i, w_imm_b;
    logic [DATA_WIDTH-1:0] w_op1, w_op2, w_alu, w_result;
    logic [31:0]           w_imem_idx;
    logic [IW-1:0]         w_fetch;

    // Instruction decode
    assign opcode    = opcode_t'(r_ir[IW-1:IW-4]);
    assign w_rd      = r_ir[2*RA_W-1:RA_W];
    assign w_rs      = r_ir[RA_W-1:0];
    assign w_imm_i   = DATA_WIDTH'(w_rs);
    assign w_imm_b   = DATA_WIDTH'(r_ir[2*RA_W-1:0]);
    assign w_rd_data = r_rf[w_rd];
    assign w_rs_data = r_rf[w_rs];

    // Fetch address wraps on the ROM depth, which need not be a power of two
    assign w_imem_idx = 32'(r_pc) % IMEM_DEPTH;
    assign w_fetch    = IMEM_INIT[w_imem_idx*IW +: IW];

    always_comb begin
        w_op1 = '0;
        case (alu_sel1)
            2'd0: w_op1 = w_rd_data;
            2'd1: w_op1 = w_imm_b;
            2'd2: w_op1 = DATA_WIDTH'(1);
            2'd3: w_op1 = '0;
        endcase
        w_op2 = '0;
        case (alu_sel2)
            2'd0: w_op2 = w_imm_i;
            2'd1: w_op2 = r_pc;
            2'd2: w_op2 = w_rs_data;
            2'd3: w_op2 = '0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (alu_op)
            AluAdd:   w_alu = w_op1 + w_op2;
            AluSub:   w_alu = w_op1 - w_op2;
            AluAnd:   w_alu = w_op1 & w_op2;
            AluOr:    w_alu = w_op1 | w_op2;
            AluXor:   w_alu = w_op1 ^ w_op2;
            AluPassA: w_alu = w_op1;
            AluPassB: w_alu = w_op2;
            AluShl:   w_alu = w_op1 << 1;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_result = '0;
        case (result_sel)
            2'd0: w_result = r_mdr;
            2'd1: w_result = r_alu_out;
            2'd2: w_result = w_alu;
            2'd3: w_result = '0;
        endcase
    end

    // Architectural state; register-file reads above see the pre-edge value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_alu_out <= '0;
            r_zero    <= 1'b0;
            for (int unsigned i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
        end else begin
            if (pc_write)   r_pc      <= w_result;
            if (ir_write)   r_ir      <= w_fetch;
            if (alu_write)  r_alu_out <= w_alu;
            if (flag_write) r_zero    <= (w_alu == '0);
            if (reg_write)  r_rf[w_rd] <= w_result;
        end
    end

    assign zero = r_zero;

`ifdef DATA_PATH_WIDE_CARRY_EN
    logic [DATA_WIDTH:0] w_sum;
    logic                r_carry;

    assign w_sum = {1'b0, w_op1} + {1'b0, w_op2};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_carry <= 1'b0;
        end else if (flag_write) begin
            r_carry <= (alu_op == AluAdd) ? w_sum[DATA_WIDTH] : 1'b0;
        end
    end

    assign carry = r_carry;
`else
    assign carry = 1'b0;
`endif

    // Memory FSM: one transaction at a time; bus fields latched on acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            r_mdr        <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (mem_start) begin
                        r_state      <= StReq;
                        r_dmem_addr  <= w_rs_data;
                        r_dmem_wdata <= w_rd_data;
                        r_dmem_we    <= mem_we;
                    end
                end
                StReq: begin
                    // A start coinciding with ack is dropped, not queued
                    if (dmem_ack) begin
                        r_state <= StIdle;
                        if (!r_dmem_we) r_mdr <= dmem_rdata;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign dmem_req   = (r_state == StReq);
    assign mem_busy   = (r_state == StReq);
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_data_path_wide.sv
// Directed bench for data_path_wide (DATA_WIDTH=8, REG_COUNT=8, IMEM_DEPTH=16).
module tb_data_path_wide;
    import data_path_wide_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned RC = 8;
    localparam int unsigned ID = 16;
    localparam int unsigned IW = 10;

    // {opcode, rd, rs}; word 0 is rightmost
    localparam logic [ID*IW-1:0] PROG = {
        {4'hF, 3'd0, 3'd0},   // 15
        {7{10'd0}},           // 14..8
        {4'h8, 3'd0, 3'd1},   // 7: rs=1 -> imm_i=1
        {4'h7, 3'd7, 3'd5},   // 6: imm_b=0x3D; store addr R5, data R7
        {4'h6, 3'd5, 3'd2},   // 5: imm_b=0x2A into R5
        {4'h5, 3'd1, 3'd2},   // 4: load addr R2, wdata R1
        {4'h4, 3'd2, 3'd0},   // 3: imm_b=0x10 into R2
        {4'h3, 3'd1, 3'd2},   // 2: R1 + R2
        {4'h2, 3'd2, 3'd0},   // 1: R2 = 1
        {4'h1, 3'd1, 3'd1}    // 0: R1 = 0 - 1
    };

    logic clk, reset;
    logic ir_write, pc_write, reg_write, alu_write, flag_write, mem_start, mem_we;
    logic [1:0] alu_sel1, alu_sel2, result_sel;
    alu_operation_t alu_op;
    opcode_t opcode;
    logic zero, carry, mem_busy, dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;

    int checks = 0;
    int errors = 0;
    int req_bursts = 0;
    int bursts_before;
    logic exp_carry;

    data_path_wide #(
        .DATA_WIDTH(DW), .REG_COUNT(RC), .IMEM_DEPTH(ID), .IMEM_INIT(PROG)
    ) dut (
        .clk(clk), .reset(reset),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_write(alu_write), .flag_write(flag_write),
        .mem_start(mem_start), .mem_we(mem_we),
        .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .result_sel(result_sel),
        .alu_op(alu_op), .opcode(opcode), .zero(zero), .carry(carry),
        .mem_busy(mem_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge dmem_req) req_bursts++;

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] rsel,
                        input alu_operation_t op, input logic pw, input logic rw,
                        input logic aw, input logic fw);
        alu_sel1 = s1; alu_sel2 = s2; result_sel = rsel; alu_op = op;
        pc_write = pw; reg_write = rw; alu_write = aw; flag_write = fw;
        tick();
        pc_write = 1'b0; reg_write = 1'b0; alu_write = 1'b0; flag_write = 1'b0;
    endtask

    // IR <= imem[PC], then PC <= PC + 1
    task automatic fetch();
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        exec(2'd2, 2'd1, 2'd2, AluAdd, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
`ifdef DATA_PATH_WIDE_CARRY_EN
        exp_carry = 1'b1;
`else
        exp_carry = 1'b0;
`endif
        ir_write = 0; pc_write = 0; reg_write = 0; alu_write = 0; flag_write = 0;
        mem_start = 0; mem_we = 0; alu_sel1 = 0; alu_sel2 = 0; result_sel = 0;
        alu_op = AluAdd; dmem_ack = 0; dmem_rdata = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #11;
        check_eq("rst_opcode", 32'(opcode), 32'h0);
        check_eq("rst_busy", 32'(mem_busy), 32'h0);
        check_eq("rst_req", 32'(dmem_req), 32'h0);
        check_eq("rst_addr", 32'(dmem_addr), 32'h0);
        check_eq("rst_zero", 32'(zero), 32'h0);
        reset = 1'b1;
        #2;

        // R1 = 0 - 1 = 0xFF; R2 = 1
        fetch();
        check_eq("fetch0_opcode", 32'(opcode), 32'h1);
        exec(2'd3, 2'd0, 2'd2, AluSub, 1'b0, 1'b1, 1'b0, 1'b0);
        fetch();
        check_eq("fetch1_opcode", 32'(opcode), 32'h2);
        exec(2'd2, 2'd3, 2'd2, AluAdd, 1'b0, 1'b1, 1'b0, 1'b0);

        // 0xFF + 0x01 -> 0x00 with carry out
        fetch();
        exec(2'd0, 2'd2, 2'd2, AluAdd, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("add_zero", 32'(zero), 32'h1);
        check_eq("add_carry", 32'(carry), 32'(exp_carry));
        // Non-add clears carry
        exec(2'd3, 2'd3, 2'd2, AluSub, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("sub_zero", 32'(zero), 32'h1);
        check_eq("sub_carry", 32'(carry), 32'h0);
        exec(2'd2, 2'd3, 2'd2, AluAdd, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("nz_zero", 32'(zero), 32'h0);
        // Flags hold without flag_write
        exec(2'd3, 2'd3, 2'd2, AluAdd, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("hold_zero", 32'(zero), 32'h0);

        // R2 = 0x10, then load from R2 with ack after 3 req cycles
        fetch();
        exec(2'd1, 2'd3, 2'd2, AluAdd, 1'b0, 1'b1, 1'b0, 1'b0);
        fetch();
        check_eq("fetch4_opcode", 32'(opcode), 32'h5);
        mem_start = 1'b1; mem_we = 1'b0;
        tick();
        mem_start = 1'b0;
        check_eq("ld_req_c1", 32'(dmem_req), 32'h1);
        check_eq("ld_busy_c1", 32'(mem_busy), 32'h1);
        check_eq("ld_addr_c1", 32'(dmem_addr), 32'h10);
        check_eq("ld_we", 32'(dmem_we), 32'h0);
        check_eq("ld_wdata", 32'(dmem_wdata), 32'hFF);
        tick();
        check_eq("ld_req_c2", 32'(dmem_req), 32'h1);
        tick();
        check_eq("ld_req_c3", 32'(dmem_req), 32'h1);
        check_eq("ld_addr_c3", 32'(dmem_addr), 32'h10);
        dmem_ack = 1'b1; dmem_rdata = 8'hA5;
        tick();
        dmem_ack = 1'b0;
        check_eq("ld_req_done", 32'(dmem_req), 32'h0);
        check_eq("ld_busy_done", 32'(mem_busy), 32'h0);
        check_eq("ld_mdr", 32'(dut.r_mdr), 32'hA5);
        // Ack while idle is ignored
        dmem_ack = 1'b1; dmem_rdata = 8'h5A;
        tick();
        dmem_ack = 1'b0;
        check_eq("idle_ack_busy", 32'(mem_busy), 32'h0);
        check_eq("idle_ack_mdr", 32'(dut.r_mdr), 32'hA5);

        // R5 = 0x2A, R7 = 0x3D, then store R7 to [R5] with start re-pulsed
        fetch();
        exec(2'd1, 2'd3, 2'd2, AluAdd, 1'b0, 1'b1, 1'b0, 1'b0);
        fetch();
        check_eq("fetch6_opcode", 32'(opcode), 32'h7);
        exec(2'd1, 2'd3, 2'd2, AluAdd, 1'b0, 1'b1, 1'b0, 1'b0);
        bursts_before = req_bursts;
        mem_start = 1'b1; mem_we = 1'b1;
        tick();
        mem_we = 1'b0;
        check_eq("st_req", 32'(dmem_req), 32'h1);
        check_eq("st_we", 32'(dmem_we), 32'h1);
        check_eq("st_addr_r5", 32'(dmem_addr), 32'h2A);
        check_eq("st_wdata_r7", 32'(dmem_wdata), 32'h3D);
        tick();
        check_eq("st_we_held", 32'(dmem_we), 32'h1);
        check_eq("st_addr_held", 32'(dmem_addr), 32'h2A);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0; mem_start = 1'b0;
        check_eq("st_ack_start_req", 32'(dmem_req), 32'h0);
        tick();
        check_eq("st_no_restart", 32'(mem_busy), 32'h0);
        check_eq("st_bursts", 32'(req_bursts - bursts_before), 32'h1);
        check_eq("st_mdr_kept", 32'(dut.r_mdr), 32'hA5);

        // PC = 0xFF, fetch wraps to imem[15], PC + 1 wraps to 0
        fetch();
        exec(2'd3, 2'd0, 2'd2, AluSub, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pc_ff", 32'(dut.r_pc), 32'hFF);
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        check_eq("fetch_ff_opcode", 32'(opcode), 32'hF);
        exec(2'd2, 2'd1, 2'd2, AluAdd, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pc_wrap", 32'(dut.r_pc), 32'h0);
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        check_eq("fetch_wrap_opcode", 32'(opcode), 32'h1);

        // Reset mid-transaction: load from R1 (0xFF)
        mem_start = 1'b1; mem_we = 1'b0;
        tick();
        mem_start = 1'b0;
        check_eq("mid_busy", 32'(mem_busy), 32'h1);
        check_eq("mid_addr", 32'(dmem_addr), 32'hFF);
        #3 reset = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(dmem_req), 32'h0);
        check_eq("mid_rst_busy", 32'(mem_busy), 32'h0);
        check_eq("mid_rst_addr", 32'(dmem_addr), 32'h0);
        check_eq("mid_rst_mdr", 32'(dut.r_mdr), 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 8'h77;
        tick();
        check_eq("mid_rst_mdr_ack", 32'(dut.r_mdr), 32'h0);
        #2 reset = 1'b1;
        dmem_ack = 1'b0;
        tick();
        check_eq("post_rst_busy", 32'(mem_busy), 32'h0);
        check_eq("post_rst_mdr", 32'(dut.r_mdr), 32'h0);
        check_eq("post_rst_opcode", 32'(opcode), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
